// File: rtl/dr_byte_loader.sv
// Byte-load sequencer: reads 1-4 bytes from the highest address down and steers them into the
// 32-bit data register. Define DR_BYTE_LOADER_TIMEOUT_EN to enable the per-byte WAIT timeout abort.
module dr_byte_loader #(
  parameter int ADDR_W  = 16,
  parameter int TIMEOUT = 16
) (
  input  logic              Clock,
  input  logic              Reset,
  input  logic              Start,
  input  logic [ADDR_W-1:0] BaseAddr,
  input  logic [1:0]        Size,
  input  logic              Signed,
  output logic [ADDR_W-1:0] MemAddr,
  output logic              MemRd,
  input  logic [7:0]        MemData,
  input  logic              MemValid,
  output logic              DR_E,
  output logic [1:0]        DR_FunSel,
  output logic [7:0]        DR_I,
  output logic              Busy,
  output logic              Done,
  output logic              Err
);

  localparam logic [1:0] FS_LOAD_SEXT = 2'b00;
  localparam logic [1:0] FS_LOAD_ZEXT = 2'b01;
  localparam logic [1:0] FS_SHL_BYTE  = 2'b10;

  if (TIMEOUT < 1) begin : g_bad_timeout
    $error("dr_byte_loader: TIMEOUT must be at least 1");
  end

`ifdef DR_BYTE_LOADER_TIMEOUT_EN
  typedef enum logic [2:0] {IDLE, REQ, WAIT, DONE, ERR} state_t;
  localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  logic [CNT_W-1:0] wait_cnt;
  logic             err_q;
`else
  typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_t;
`endif

  state_t     state;
  logic [1:0] remaining;
  logic       first_byte;
  logic       sgn;

  // The first (most significant) byte loads with extension; the rest shift in from the right.
  function automatic logic [1:0] byte_funsel(input logic is_first, input logic sext);
    if (!is_first)
      return FS_SHL_BYTE;
    return sext ? FS_LOAD_SEXT : FS_LOAD_ZEXT;
  endfunction

  assign DR_I      = MemData;
  assign DR_E      = (state == WAIT) && MemValid;
  assign DR_FunSel = DR_E ? byte_funsel(first_byte, sgn) : FS_LOAD_ZEXT;

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      state      <= IDLE;
      MemAddr    <= '0;
      MemRd      <= 1'b0;
      Busy       <= 1'b0;
      Done       <= 1'b0;
      remaining  <= 2'd0;
      first_byte <= 1'b0;
      sgn        <= 1'b0;
`ifdef DR_BYTE_LOADER_TIMEOUT_EN
      wait_cnt   <= '0;
      err_q      <= 1'b0;
`endif
    end else begin
      MemRd <= 1'b0;
      Done  <= 1'b0;
`ifdef DR_BYTE_LOADER_TIMEOUT_EN
      err_q <= 1'b0;
`endif
      case (state)
        IDLE: begin
          if (Start) begin
            sgn        <= Signed;
            remaining  <= Size;
            first_byte <= 1'b1;
            MemAddr    <= BaseAddr + ADDR_W'(Size);
            MemRd      <= 1'b1;
            Busy       <= 1'b1;
            state      <= REQ;
          end
        end
        REQ: begin
          state <= WAIT;
`ifdef DR_BYTE_LOADER_TIMEOUT_EN
          wait_cnt <= '0;
`endif
        end
        WAIT: begin
          if (MemValid) begin
            first_byte <= 1'b0;
            if (remaining == 2'd0) begin
              Done  <= 1'b1;
              state <= DONE;
            end else begin
              remaining <= remaining - 2'd1;
              MemAddr   <= MemAddr - ADDR_W'(1);
              MemRd     <= 1'b1;
              state     <= REQ;
            end
          end
`ifdef DR_BYTE_LOADER_TIMEOUT_EN
          // wait_cnt counts completed empty WAIT cycles; the TIMEOUT-th one aborts.
          else if (wait_cnt == CNT_W'(TIMEOUT - 1)) begin
            err_q <= 1'b1;
            state <= ERR;
          end else begin
            wait_cnt <= wait_cnt + CNT_W'(1);
          end
`endif
        end
        DONE: begin
          Busy  <= 1'b0;
          state <= IDLE;
        end
`ifdef DR_BYTE_LOADER_TIMEOUT_EN
        ERR: begin
          Busy  <= 1'b0;
          state <= IDLE;
        end
`endif
        default: begin
          Busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

`ifdef DR_BYTE_LOADER_TIMEOUT_EN
  assign Err = err_q;
`else
  assign Err = 1'b0;
`endif

endmodule

// File: tb/tb_dr_byte_loader.sv
// Directed bench for dr_byte_loader: byte memory responder with per-byte latency plus a
// behavioural data-register model; results checked against hand-computed values.
module tb_dr_byte_loader;

  logic        Clock;
  logic        Reset;
  logic        Start;
  logic [15:0] BaseAddr;
  logic [1:0]  Size;
  logic        sgn_in;
  logic [15:0] MemAddr;
  logic        MemRd;
  logic [7:0]  MemData;
  logic        MemValid;
  logic        DR_E;
  logic [1:0]  DR_FunSel;
  logic [7:0]  DR_I;
  logic        Busy;
  logic        Done;
  logic        Err;

  dr_byte_loader #(.ADDR_W(16), .TIMEOUT(16)) dut (
    .Clock(Clock), .Reset(Reset), .Start(Start), .BaseAddr(BaseAddr), .Size(Size),
    .Signed(sgn_in), .MemAddr(MemAddr), .MemRd(MemRd), .MemData(MemData),
    .MemValid(MemValid), .DR_E(DR_E), .DR_FunSel(DR_FunSel), .DR_I(DR_I),
    .Busy(Busy), .Done(Done), .Err(Err)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
    end
  endtask

  int cyc = 0;
  always @(posedge Clock) cyc <= cyc + 1;

  // Behavioural data register.
  logic [31:0] dr;
  always @(posedge Clock) begin
    if (DR_E) begin
      case (DR_FunSel)
        2'b00:   dr <= {{24{DR_I[7]}}, DR_I};
        2'b01:   dr <= {24'h0, DR_I};
        2'b10:   dr <= {dr[23:0], DR_I};
        default: dr <= 32'hDEADBEEF;
      endcase
    end
  end

  // Byte memory responder: extra wait cycles per byte come from ext[].
  logic [7:0]  mem [0:65535];
  logic [15:0] addr_log [0:7];
  int          ext [0:3];
  int          rd_count = 0;
  bit          resp_en = 1'b1;
  bit          stray = 1'b0;
  bit          pend = 1'b0;
  int          wait_left = 0;
  logic [15:0] paddr;

  initial begin
    MemValid = 1'b0;
    MemData  = 8'h00;
    forever begin
      @(posedge Clock); #1;
      MemValid = 1'b0;
      if (pend) begin
        if (wait_left == 0) begin
          MemValid = 1'b1;
          MemData  = mem[paddr];
          pend     = 1'b0;
        end else begin
          wait_left--;
        end
      end
      if (MemRd && resp_en) begin
        if (rd_count < 8) addr_log[rd_count] = MemAddr;
        pend      = 1'b1;
        paddr     = MemAddr;
        wait_left = ext[rd_count & 3];
        rd_count++;
        if (stray) begin
          MemValid = 1'b1;
          MemData  = 8'hEE;
          stray    = 1'b0;
        end
      end
    end
  end

  int t0;
  int done_edge;
  bit poke = 1'b0;

  task automatic start_load(input logic [15:0] base, input logic [1:0] sz, input logic s);
    @(negedge Clock);
    rd_count = 0;
    BaseAddr = base;
    Size     = sz;
    sgn_in   = s;
    Start    = 1'b1;
    @(posedge Clock); #1;
    t0       = cyc;
    Start    = 1'b0;
    BaseAddr = 16'hAAAA;
    Size     = 2'b00;
    sgn_in   = ~s;
  endtask

  task automatic wait_done(input string tag);
    done_edge = 999;
    for (int i = 0; i < 200; i++) begin
      @(posedge Clock); #1;
      if (poke) Start = (i == 4);
      if (Done) begin
        done_edge = cyc - t0;
        break;
      end
    end
    Start = 1'b0;
    if (done_edge == 999) check_val({tag, "_done_seen"}, 0, 1);
    @(posedge Clock); #1;
    check_val({tag, "_done_pulse"}, {30'd0, Done, Busy}, 32'd0);
  endtask

  initial begin
    Reset = 1'b0; Start = 1'b0; BaseAddr = '0; Size = '0; sgn_in = 1'b0;
    for (int i = 0; i < 4; i++) ext[i] = 0;
    mem[16'h0010] = 8'h11; mem[16'h0011] = 8'h22; mem[16'h0012] = 8'h33; mem[16'h0013] = 8'h44;
    mem[16'h0020] = 8'h80; mem[16'h0021] = 8'hFF; mem[16'h0030] = 8'h9A;
    mem[16'hFFFE] = 8'h01; mem[16'hFFFF] = 8'h02; mem[16'h0000] = 8'h83; mem[16'h0001] = 8'hC4;

    repeat (3) @(posedge Clock);
    #1;
    check_val("rst_memaddr", {16'd0, MemAddr}, 32'd0);
    check_val("rst_memrd", {31'd0, MemRd}, 32'd0);
    check_val("rst_dr_e", {31'd0, DR_E}, 32'd0);
    check_val("rst_funsel", {30'd0, DR_FunSel}, 32'd1);
    check_val("rst_busy", {31'd0, Busy}, 32'd0);
    check_val("rst_done", {31'd0, Done}, 32'd0);
    check_val("rst_err", {31'd0, Err}, 32'd0);
    @(negedge Clock) Reset = 1'b1;

    // Word load, 1-cycle memory.
    start_load(16'h0010, 2'b11, 1'b0);
    wait_done("word");
    check_val("word_dr", dr, 32'h44332211);
    check_val("word_a0", {16'd0, addr_log[0]}, 32'h13);
    check_val("word_a1", {16'd0, addr_log[1]}, 32'h12);
    check_val("word_a2", {16'd0, addr_log[2]}, 32'h11);
    check_val("word_a3", {16'd0, addr_log[3]}, 32'h10);
    check_val("word_rds", rd_count, 4);
    check_val("word_done_edge", done_edge, 8);
    check_val("idle_funsel", {30'd0, DR_FunSel}, 32'd1);

    // Halfword, signed and unsigned.
    start_load(16'h0020, 2'b01, 1'b1);
    wait_done("hws");
    check_val("hws_dr", dr, 32'hFFFFFF80);
    check_val("hws_done_edge", done_edge, 4);
    start_load(16'h0020, 2'b01, 1'b0);
    wait_done("hwu");
    check_val("hwu_dr", dr, 32'h0000FF80);

    // Single byte.
    start_load(16'h0030, 2'b00, 1'b1);
    wait_done("bs");
    check_val("bs_dr", dr, 32'hFFFFFF9A);
    check_val("bs_rds", rd_count, 1);
    check_val("bs_done_edge", done_edge, 2);
    start_load(16'h0030, 2'b00, 1'b0);
    wait_done("bu");
    check_val("bu_dr", dr, 32'h0000009A);
    check_val("bu_rds", rd_count, 1);

    // Wrap-around, variable latency, stray valid in REQ, Start pulse mid-load.
    ext[0] = 1; ext[1] = 3; ext[2] = 2; ext[3] = 1;
    stray = 1'b1;
    poke  = 1'b1;
    start_load(16'hFFFE, 2'b11, 1'b1);
    wait_done("wrap");
    poke  = 1'b0;
    check_val("wrap_dr", dr, 32'hC4830201);
    check_val("wrap_a0", {16'd0, addr_log[0]}, 32'h0001);
    check_val("wrap_a1", {16'd0, addr_log[1]}, 32'h0000);
    check_val("wrap_a2", {16'd0, addr_log[2]}, 32'hFFFF);
    check_val("wrap_a3", {16'd0, addr_log[3]}, 32'hFFFE);
    check_val("wrap_rds", rd_count, 4);
    check_val("wrap_done_edge", done_edge, 15);

    // Reset during the second WAIT of a word load.
    ext[0] = 0; ext[1] = 5; ext[2] = 0; ext[3] = 0;
    start_load(16'h0010, 2'b11, 1'b0);
    for (int i = 0; i < 20 && rd_count < 2; i++) begin
      @(posedge Clock); #1;
    end
    check_val("rst_mid_rds", rd_count, 2);
    @(posedge Clock); #2;
    Reset = 1'b0;
    #1;
    check_val("rst_mid_busy", {31'd0, Busy}, 32'd0);
    check_val("rst_mid_memrd", {31'd0, MemRd}, 32'd0);
    check_val("rst_mid_dr_e", {31'd0, DR_E}, 32'd0);
    repeat (2) @(posedge Clock);
    @(negedge Clock) Reset = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(posedge Clock); #1;
      if (MemValid) check_val("late_vld_dr_e", {31'd0, DR_E}, 32'd0);
    end
    check_val("rst_mid_dr_hold", dr, 32'h00000044);
    ext[1] = 0;
    start_load(16'h0030, 2'b00, 1'b0);
    wait_done("post_rst");
    check_val("post_rst_dr", dr, 32'h0000009A);
    check_val("post_rst_done_edge", done_edge, 2);

`ifdef DR_BYTE_LOADER_TIMEOUT_EN
    begin
      int  err_edge;
      bit  saw_done;
      err_edge = 999;
      saw_done = 1'b0;
      resp_en  = 1'b0;
      start_load(16'h0010, 2'b11, 1'b0);
      for (int i = 0; i < 100; i++) begin
        @(posedge Clock); #1;
        if (Done) saw_done = 1'b1;
        if (Err) begin
          err_edge = cyc - t0;
          break;
        end
      end
      check_val("to_err_edge", err_edge, 17);
      check_val("to_busy_in_err", {31'd0, Busy}, 32'd1);
      @(posedge Clock); #1;
      check_val("to_after", {29'd0, Err, Busy, saw_done}, 32'd0);
      resp_en = 1'b1;
    end
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
